pulse_qual_ctrl: RTL and testbench
==================================

# pulse_qual_ctrl

Multi-channel pulse qualifier and event scheduler for the glitch-filter path. Each of NCH synchronous input lines is width-measured against a runtime-programmable minimum-length threshold. Qualified lines drive a level-type `clean` output. When each qualified pulse ends, a width event is queued, and a round-robin arbiter serialises events from all channels onto one valid/ready event port for downstream logging.

## Interface

Parameters:
- `NCH`, 4: number of input channels (2..8).
- `CW`, 8: width of the pulse-length counter and threshold.
- `THR_RST`, 6: threshold value loaded at reset.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sig`  in  NCH  raw pulse lines, already synchronous to `clk`.
- `cfg_we`  in  1  threshold write strobe.
- `cfg_thr`  in  CW  new threshold, taken when `cfg_we`=1.
- `ovf_clr`  in  1  clears all `ovf` bits.
- `clean`  out  NCH  filtered level per channel.
- `evt_valid`  out  1  event available.
- `evt_ready`  in  1  consumer accepts the event.
- `evt_ch`  out  clog2(NCH)  channel index of the event.
- `evt_width`  out  CW  measured high length in cycles, saturating.
- `ovf`  out  NCH  sticky flag: an event was dropped on this channel.

## Operation

- Reset state:
  - `clean`, `evt_valid`, `evt_ch`, `evt_width` and `ovf` are all 0.
  - Threshold is `THR_RST`.
  - All counters and pending slots are clear.
  - Round-robin pointer is 0.
- Per-channel counter `cnt[i]`:
  - Increments on every edge where `sig[i]`=1, saturating at 2^CW-1.
  - Loads 0 on every edge where `sig[i]`=0.
- Effective threshold `thr_e` is `max(thr,1)`. Writing 0 behaves as 1.
- `clean[i]` set: on the edge where `sig[i]`=1 and `cnt[i]+1 >= thr_e`, i.e. on the thr_e-th consecutive high sample.
- `clean[i]` clear: on the first edge where `sig[i]`=0.
- Pulse capture: on an edge where `sig[i]`=0 and `clean[i]`=1, `cnt[i]` (the full high length, saturated) is written into the pending slot `pend[i]`.
  - If the slot is already full and is not being drained on the same edge, the new width is dropped, the old width is kept, and `ovf[i]` is set.
  - A pulse that ends before qualifying produces no event.
- Output stage:
  - The output register is free when `evt_valid`=0, or when `evt_valid`=1 and `evt_ready`=1.
  - When free, the lowest pending channel at or after the pointer (cyclically) is granted.
  - On grant: its width and index are loaded into the output, `evt_valid` is set to 1, the slot is cleared, and the pointer becomes granted+1 mod NCH.
  - If nothing is pending and the current event is accepted, `evt_valid` drops to 0.
- Capture and drain of the same slot on the same edge: the old width goes to the output and the new width fills the slot. No overflow.
- `ovf` bits clear only on `ovf_clr` or `rst`. If a new overflow and `ovf_clr` occur on the same edge, the set wins.
- Threshold write:
  - Takes effect for comparisons from the next edge.
  - An already-high `clean` stays high until its pulse ends.
  - A lower threshold can qualify an in-progress pulse on the next edge.

## Timing

- For a pulse sampled high at edges k .. k+L-1 and low at edge k+L:
  - `clean` rises after edge k+thr_e-1 (only if L >= thr_e).
  - `clean` falls after edge k+L.
  - The pending slot is written at edge k+L.
  - `evt_valid` is asserted after edge k+L+1 at the earliest, with `evt_width`=L.
- Throughput: one event per cycle while `evt_ready`=1.
- `evt_ch` and `evt_width` hold stable while `evt_valid`=1 and `evt_ready`=0.
- Asynchronous `rst` mid-pulse or mid-event:
  - Everything clears immediately.
  - A line still high after `rst` is released counts from 0.

## Test plan

- Glitch: `sig[0]` high for 3 cycles, thr=6 -> `clean[0]` stays 0, no event, `ovf`=0.
- Valid pulse: `sig[0]` high for 7 cycles -> `clean[0]` rises after the 6th high edge and falls 1 edge after `sig` drops; next edge gives `evt_valid`=1, `evt_ch`=0, `evt_width`=7.
- Simultaneous pulses: `sig[2]` and `sig[0]` each high for 8 cycles, both ending on the same edge, `evt_ready`=1 -> back-to-back events ch0 then ch2 on consecutive cycles. A second identical pair then yields ch0 then ch2 again, because the pointer sits at 3 and wraps.
- Backpressure and overflow: `evt_ready`=0, three qualified pulses on ch1 with widths 6, 9, 12 -> output holds width 6, slot holds 9, 12 is dropped and `ovf[1]`=1. Raising `ready` gives events 6 then 9. `ovf_clr` clears `ovf[1]`.
- Reconfiguration and saturation:
  - Write thr=3 -> a 3-cycle pulse qualifies with `evt_width`=3.
  - Write thr=0 -> a 1-cycle pulse qualifies.
  - A 300-cycle pulse with CW=8 -> `evt_width`=255.
- Reset mid-pulse: assert `rst` at cycle 4 of a 10-cycle pulse -> all outputs 0 at once. After release the remaining 5 high cycles do not qualify (thr=6) and no event is produced.

Source files
------------

// File: rtl/pulse_qual_ctrl.sv
// Multi-channel pulse qualifier with a width-event scheduler.
// Each line is measured while high. A pulse that reaches the threshold raises
// its clean level. When that pulse ends, its width is parked in a one-deep
// per-channel slot. A round-robin arbiter then moves parked widths into a
// single valid/ready output register.
`timescale 1ns/1ps
module pulse_qual_ctrl #(
  parameter int NCH     = 4,
  parameter int CW      = 8,
  parameter int THR_RST = 6
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NCH-1:0]                        sig,
  input  logic                                  cfg_we,
  input  logic [CW-1:0]                         cfg_thr,
  input  logic                                  ovf_clr,
  output logic [NCH-1:0]                        clean,
  output logic                                  evt_valid,
  input  logic                                  evt_ready,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] evt_ch,
  output logic [CW-1:0]                         evt_width,
  output logic [NCH-1:0]                        ovf
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] CMAX = '1;

  logic [CW-1:0]  thr_reg;
  logic [CW-1:0]  thr_e;
  logic [NCH-1:0] clean_vec;
  logic [NCH-1:0] pend_v;
  logic [CW-1:0]  pend_w [NCH];
  logic [NCH-1:0] cap;
  logic [NCH-1:0] drain;
  logic [NCH-1:0] ovf_set;
  logic [NCH-1:0] ovf_reg;
  logic           evt_valid_reg;
  logic [CHW-1:0] evt_ch_reg;
  logic [CW-1:0]  evt_width_reg;
  logic [CHW-1:0] ptr_reg;
  logic [CHW-1:0] ptr_next;
  logic           out_free;
  logic           grant_found;
  logic [CHW-1:0] grant_idx;
  logic [CHW:0]   scan_idx;

  // A programmed threshold of zero is treated as one: every pulse that is
  // sampled high at least once qualifies.
  assign thr_e = (thr_reg == '0) ? CW'(1) : thr_reg;

  // Threshold register. A write affects comparisons from the next edge onward.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_reg <= CW'(THR_RST);
    end else if (cfg_we) begin
      thr_reg <= cfg_thr;
    end
  end

  // Each channel owns its counter, its clean flag and its pending slot.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [CW-1:0] cnt_reg;
    logic          clean_reg;
    logic          pend_v_reg;
    logic [CW-1:0] pend_w_reg;
    logic [CW:0]   cnt_inc;

    assign cnt_inc     = {1'b0, cnt_reg} + (CW+1)'(1);
    assign cap[gi]     = ~sig[gi] & clean_reg;
    // An overflow happens when a capture hits a full slot that is not being
    // emptied by the arbiter on the same edge.
    assign ovf_set[gi] = cap[gi] & pend_v_reg & ~drain[gi];

    // Counter and clean level. Once set, clean stays high until the line drops,
    // even if the threshold is raised in the meantime.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg   <= '0;
        clean_reg <= 1'b0;
      end else if (sig[gi]) begin
        if (cnt_reg != CMAX) cnt_reg <= cnt_inc[CW-1:0];
        if (cnt_inc >= {1'b0, thr_e}) clean_reg <= 1'b1;
      end else begin
        cnt_reg   <= '0;
        clean_reg <= 1'b0;
      end
    end

    // Pending slot. A capture can refill the slot on the same edge it drains.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pend_v_reg <= 1'b0;
        pend_w_reg <= '0;
      end else if (cap[gi] && (!pend_v_reg || drain[gi])) begin
        pend_v_reg <= 1'b1;
        pend_w_reg <= cnt_reg;
      end else if (drain[gi]) begin
        pend_v_reg <= 1'b0;
      end
    end

    assign clean_vec[gi] = clean_reg;
    assign pend_v[gi]    = pend_v_reg;
    assign pend_w[gi]    = pend_w_reg;
  end

  // Round-robin search. Scanning from the farthest offset down to zero lets
  // the nearest pending channel at or after the pointer win.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr_reg} + (CHW+1)'(k);
      if (scan_idx >= (CHW+1)'(NCH)) scan_idx = scan_idx - (CHW+1)'(NCH);
      if (pend_v[scan_idx[CHW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx[CHW-1:0];
      end
    end
  end

  assign out_free = ~evt_valid_reg | evt_ready;
  assign drain    = (out_free && grant_found) ? (NCH'(1) << grant_idx) : '0;
  assign ptr_next = (grant_idx == CHW'(NCH - 1)) ? '0 : grant_idx + CHW'(1);

  // Output register. It loads a granted event whenever it is empty or its
  // current event is being accepted. Otherwise it holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid_reg <= 1'b0;
      evt_ch_reg    <= '0;
      evt_width_reg <= '0;
      ptr_reg       <= '0;
    end else if (out_free) begin
      if (grant_found) begin
        evt_valid_reg <= 1'b1;
        evt_ch_reg    <= grant_idx;
        evt_width_reg <= pend_w[grant_idx];
        ptr_reg       <= ptr_next;
      end else begin
        evt_valid_reg <= 1'b0;
      end
    end
  end

  // Sticky overflow flags. A new overflow wins over a clear on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_reg <= '0;
    end else begin
      ovf_reg <= (ovf_clr ? '0 : ovf_reg) | ovf_set;
    end
  end

  assign clean     = clean_vec;
  assign evt_valid = evt_valid_reg;
  assign evt_ch    = evt_ch_reg;
  assign evt_width = evt_width_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_pulse_qual_ctrl.sv
// Directed bench for pulse_qual_ctrl. A behavioural model tracks run lengths,
// pending widths and the round-robin order, and outputs are compared against
// it on every falling edge. Literal checks pin the model to hand-derived values.
`timescale 1ns/1ps
module tb_pulse_qual_ctrl;
  localparam int NCH = 4;
  localparam int CW  = 8;
  localparam int WMAX = 255;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] sig;
  logic           cfg_we;
  logic [CW-1:0]  cfg_thr;
  logic           ovf_clr;
  logic [NCH-1:0] clean;
  logic           evt_valid;
  logic           evt_ready;
  logic [1:0]     evt_ch;
  logic [CW-1:0]  evt_width;
  logic [NCH-1:0] ovf;

  pulse_qual_ctrl #(.NCH(NCH), .CW(CW), .THR_RST(6)) dut (
    .clk(clk), .rst(rst), .sig(sig), .cfg_we(cfg_we), .cfg_thr(cfg_thr),
    .ovf_clr(ovf_clr), .clean(clean), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_ch(evt_ch), .evt_width(evt_width), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int ch; int w; int cyc; } ev_t;
  ev_t log_q[$];

  int m_run  [NCH] = '{default: 0};
  int m_pend [NCH] = '{default: -1};
  bit m_cl   [NCH] = '{default: 1'b0};
  bit [NCH-1:0] m_ovf = '0;
  bit m_ov  = 1'b0;
  int m_ch  = 0;
  int m_w   = 0;
  int m_ptr = 0;
  int m_thr = 6;
  int cyc   = 0;
  int mdl_thr_e, mdl_g, mdl_c, mdl_w;
  bit mdl_free;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_run[i] = 0; m_pend[i] = -1; m_cl[i] = 1'b0;
      end
      m_ovf = '0; m_ov = 1'b0; m_ch = 0; m_w = 0; m_ptr = 0; m_thr = 6;
    end else begin
      mdl_thr_e = (m_thr == 0) ? 1 : m_thr;
      mdl_free  = !m_ov || evt_ready;
      if (m_ov && evt_ready) log_q.push_back('{m_ch, m_w, cyc});
      if (mdl_free) begin
        mdl_g = -1;
        for (int k = 0; k < NCH; k++) begin
          mdl_c = (m_ptr + k) % NCH;
          if (mdl_g < 0 && m_pend[mdl_c] >= 0) mdl_g = mdl_c;
        end
        if (mdl_g >= 0) begin
          m_ov = 1'b1; m_ch = mdl_g; m_w = m_pend[mdl_g];
          m_pend[mdl_g] = -1; m_ptr = (mdl_g + 1) % NCH;
        end else begin
          m_ov = 1'b0;
        end
      end
      if (ovf_clr) m_ovf = '0;
      for (int i = 0; i < NCH; i++) begin
        if (sig[i]) begin
          m_run[i]++;
          if (m_run[i] >= mdl_thr_e) m_cl[i] = 1'b1;
        end else begin
          if (m_cl[i]) begin
            mdl_w = (m_run[i] > WMAX) ? WMAX : m_run[i];
            if (m_pend[i] < 0) m_pend[i] = mdl_w;
            else m_ovf[i] = 1'b1;
          end
          m_cl[i] = 1'b0;
          m_run[i] = 0;
        end
      end
      if (cfg_we) m_thr = int'(cfg_thr);
      cyc++;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) chk("clean_model", clean[i], m_cl[i]);
    chk("evt_valid_model", evt_valid, m_ov);
    chk("ovf_model", ovf, m_ovf);
    if (m_ov) begin
      chk("evt_ch_model", evt_ch, m_ch);
      chk("evt_width_model", evt_width, m_w);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  task automatic write_thr(input int t);
    cfg_we = 1'b1; cfg_thr = CW'(t);
    step(1);
    cfg_we = 1'b0;
  endtask

  int n0;

  initial begin
    rst = 1'b1; sig = '0; cfg_we = 1'b0; cfg_thr = '0; ovf_clr = 1'b0; evt_ready = 1'b1;
    step(2);
    chk("rst_clean", clean, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_ch", evt_ch, 0);
    chk("rst_width", evt_width, 0);
    chk("rst_ovf", ovf, 0);
    rst = 1'b0;
    step(1);

    // Glitch: three high samples with a threshold of 6.
    sig = 4'b0001; step(3); sig = '0; step(6);
    chk("glitch_events", log_q.size(), 0);
    chk("glitch_clean", clean, 0);
    chk("glitch_ovf", ovf, 0);

    // Valid 7-cycle pulse. Check the edge timing by hand.
    sig = 4'b0001; step(5);
    chk("p7_clean_e5", clean[0], 0);
    step(1);
    chk("p7_clean_e6", clean[0], 1);
    step(1);
    sig = '0; step(1);
    chk("p7_clean_fall", clean[0], 0);
    chk("p7_valid_early", evt_valid, 0);
    step(1);
    chk("p7_valid", evt_valid, 1);
    chk("p7_ch", evt_ch, 0);
    chk("p7_width", evt_width, 7);
    step(3);
    chk("p7_logged", log_q.size(), 1);

    // Simultaneous pulses on ch0 and ch2, twice. The second pair wraps the pointer.
    do_reset();
    n0 = log_q.size();
    sig = 4'b0101; step(8); sig = '0; step(6);
    sig = 4'b0101; step(8); sig = '0; step(6);
    chk("sim_count", log_q.size(), n0 + 4);
    chk("sim_a_ch", log_q[n0].ch, 0);
    chk("sim_a_w", log_q[n0].w, 8);
    chk("sim_b_ch", log_q[n0+1].ch, 2);
    chk("sim_b_w", log_q[n0+1].w, 8);
    chk("sim_b_b2b", log_q[n0+1].cyc, log_q[n0].cyc + 1);
    chk("sim_c_ch", log_q[n0+2].ch, 0);
    chk("sim_d_ch", log_q[n0+3].ch, 2);
    chk("sim_d_b2b", log_q[n0+3].cyc, log_q[n0+2].cyc + 1);

    // Backpressure and overflow on ch1: widths 6, 9, 12.
    do_reset();
    evt_ready = 1'b0;
    sig = 4'b0010; step(6);  sig = '0; step(3);
    sig = 4'b0010; step(9);  sig = '0; step(3);
    sig = 4'b0010; step(12); sig = '0; step(3);
    chk("bp_valid", evt_valid, 1);
    chk("bp_ch", evt_ch, 1);
    chk("bp_width_held", evt_width, 6);
    chk("bp_ovf", ovf, 4'b0010);
    n0 = log_q.size();
    evt_ready = 1'b1; step(4);
    chk("bp_count", log_q.size(), n0 + 2);
    chk("bp_first", log_q[n0].w, 6);
    chk("bp_second", log_q[n0+1].w, 9);
    chk("bp_ovf_sticky", ovf, 4'b0010);
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    chk("bp_ovf_clr", ovf, 0);

    // Reconfiguration and saturation.
    write_thr(3);
    sig = 4'b0001; step(3); sig = '0; step(4);
    chk("thr3_width", log_q[log_q.size()-1].w, 3);
    write_thr(0);
    sig = 4'b1000; step(1); sig = '0; step(4);
    chk("thr0_ch", log_q[log_q.size()-1].ch, 3);
    chk("thr0_width", log_q[log_q.size()-1].w, 1);
    sig = 4'b0001; step(300); sig = '0; step(4);
    chk("sat_width", log_q[log_q.size()-1].w, 255);
    // Lower the threshold while a pulse is already in progress.
    write_thr(6);
    sig = 4'b0100; step(3);
    cfg_we = 1'b1; cfg_thr = 8'd2; step(1); cfg_we = 1'b0;
    step(1);
    chk("lower_thr_clean", clean[2], 1);
    sig = '0; step(4);
    chk("lower_thr_width", log_q[log_q.size()-1].w, 5);
    write_thr(6);

    // Reset in the middle of a 10-cycle pulse.
    sig = 4'b0001; step(4);
    rst = 1'b1;
    #1;
    chk("mid_rst_clean", clean, 0);
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_width", evt_width, 0);
    chk("mid_rst_ovf", ovf, 0);
    step(1);
    rst = 1'b0;
    n0 = log_q.size();
    step(5); sig = '0; step(5);
    chk("mid_rst_no_evt", log_q.size(), n0);
    chk("mid_rst_clean_after", clean, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
